bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Round-robin arbiter that shares the single memory bus between the front-end and back-end clients.
- Clients are the ITLB walker, ICache, DTLB walker and DCache, each driving the existing `*_abtr_reqcyc` / `*_abtr_grant` / `*_bus_busy` triple.
- Grants exactly one owner at a time and holds the grant for the whole bus transaction.
- Revokes grants that are abandoned or never used, then rotates priority.

Parameters:
- NUM_REQ, 4, number of requesters. Index 0 = ITLB walk, 1 = ICache, 2 = DTLB walk, 3 = DCache.
- GRANT_TIMEOUT, 16, cycles a grant may sit unused (busy low) before revocation. 0 disables the timeout.
- OWNER_W, $clog2(NUM_REQ), width of the owner index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- abtr_reqcyc  in  NUM_REQ  per-requester bus request, level, held until granted or abandoned.
- bus_busy  in  NUM_REQ  per-requester "transaction in flight", asserted by the owner while using the bus.
- abtr_grant  out  NUM_REQ  one-hot-or-zero registered grant.
- owner_id  out  OWNER_W  index of the current grantee, valid when owner_valid=1.
- owner_valid  out  1  1 in GRANT and BUSY states.
- timeout_pulse  out  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (reset=0, async): state=IDLE, abtr_grant=0, owner_id=0, owner_valid=0, timeout_pulse=0, counter=0, last_owner=NUM_REQ-1 (so requester 0 wins first).
- All outputs are registered. No combinational path from the inputs to abtr_grant.

States:
- IDLE:
  - if any abtr_reqcyc: pick the first set bit searching from last_owner+1 upward, wrapping modulo NUM_REQ.
  - Load owner, set abtr_grant[owner]=1, counter=0, go to GRANT.
  - Grant is visible the cycle after reqcyc is first sampled (1-cycle latency).
- GRANT:
  - if bus_busy[owner]: go to BUSY (grant held).
  - else if !abtr_reqcyc[owner]: abandoned; drop grant, go to RELEASE.
  - else if GRANT_TIMEOUT!=0 and counter==GRANT_TIMEOUT-1: drop grant, pulse timeout_pulse, go to RELEASE.
  - else counter++.
- BUSY:
  - Grant held regardless of abtr_reqcyc.
  - When bus_busy[owner]==0: drop grant, go to RELEASE.
- RELEASE:
  - abtr_grant=0, owner_valid=0 for exactly one turnaround cycle.
  - last_owner<=owner, go to IDLE.
  - Requests are not sampled in this state.

Rules:
- Minimum gap between two grants is 2 cycles (RELEASE then IDLE).
- bus_busy from non-owners is ignored.
- A requester holding abtr_reqcyc continuously is served again only after all other active requesters have been served once.
- Timeout and abandonment still rotate last_owner, so a stuck requester cannot starve the others.
- abtr_reqcyc and bus_busy of the owner both falling in GRANT in the same cycle: treated as abandon.
- Priority among simultaneous conditions in GRANT: busy > abandon > timeout.
- Counter width is $clog2(GRANT_TIMEOUT+1). The counter saturates and is never compared when GRANT_TIMEOUT=0.
- Reset asserted mid-BUSY: grant drops asynchronously to 0. After release, requester 0 has top priority again.
- Assertions (bench): $onehot0(abtr_grant) every cycle; abtr_grant!=0 implies owner_valid.

Test Plan:
- Single requester: reqcyc[1]=1 at cycle 0 → grant=0010 at cycle 1. busy[1] high cycles 2–9 → grant held through cycle 10; grant=0 at cycle 11; owner_valid=0 at cycle 11.
- Contention: all four reqcyc=1 from reset, each owner runs busy for 3 cycles → grant order 0,1,2,3,0. Each grant is separated by ≥1 cycle with grant=0.
- Abandon: reqcyc[2] rises for 2 cycles, then falls before any busy → grant[2] drops one cycle later, no timeout_pulse, next grant goes to index 3 if requesting.
- Timeout: GRANT_TIMEOUT=4, reqcyc[3] held, busy never asserted → grant[3] high exactly 4 cycles, timeout_pulse=1 on the revoke edge, next winner is 0.
- Reset mid-transaction: owner 1 in BUSY, reset=0 asynchronously between clock edges → grant=0000 immediately. After deassertion with reqcyc=1111, first grant=0001.
- Non-owner busy: owner 0 in GRANT, busy[2]=1 only → stays in GRANT, grant unchanged.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_rr
// Description : Round-robin arbiter for the shared memory bus. Clients are
//               ITLB walker (0), ICache (1), DTLB walker (2) and DCache (3).
//               One owner at a time; the grant is held for the whole bus
//               transaction, revoked when abandoned or left unused, and
//               priority rotates after every release.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
    parameter int NUM_REQ       = 4,
    parameter int GRANT_TIMEOUT = 16,
    parameter int OWNER_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [NUM_REQ-1:0] abtr_reqcyc_i,
    input  logic [NUM_REQ-1:0] bus_busy_i,
    output logic [NUM_REQ-1:0] abtr_grant_o,
    output logic [OWNER_W-1:0] owner_id_o,
    output logic               owner_valid_o,
    output logic               timeout_pulse_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The counter only has to reach GRANT_TIMEOUT-1; a zero timeout still
    // keeps a 1-bit counter so the datapath stays well formed.
    localparam int CNT_W = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;

    localparam bit               TIMEOUT_EN = (GRANT_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = (GRANT_TIMEOUT > 0) ?
                                              CNT_W'(GRANT_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // Previous owner after reset is the highest index so requester 0 wins first
    localparam logic [OWNER_W-1:0] LAST_OWNER_RST = OWNER_W'(NUM_REQ - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    state_e             state_q,        state_d;
    logic [NUM_REQ-1:0] grant_q,        grant_d;
    logic [OWNER_W-1:0] owner_q,        owner_d;
    logic               owner_valid_q,  owner_valid_d;
    logic               timeout_q,      timeout_d;
    logic [CNT_W-1:0]   cnt_q,          cnt_d;
    logic [OWNER_W-1:0] last_owner_q,   last_owner_d;

    // Round-robin search results
    logic               pick_found;
    logic [OWNER_W-1:0] pick_idx;
    logic [OWNER_W-1:0] cand;

    // Owner-side views of the request and busy vectors
    logic               owner_req;
    logic               owner_busy;
    logic               timeout_hit;

    // ------------------------------------------------------------------------
    // Rotating priority search, starting just after the previous owner
    // ------------------------------------------------------------------------
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = OWNER_W'((int'(last_owner_q) + i) % NUM_REQ);
            if (!pick_found && abtr_reqcyc_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Only the current owner's request/busy lines matter; everybody else's
    // busy is ignored so a misbehaving client cannot hold someone else's grant
    // Timeout compare is masked when the timeout is disabled.
    always_comb begin
        owner_req   = abtr_reqcyc_i[owner_q];
        owner_busy  = bus_busy_i[owner_q];
        timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);
    end

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        timeout_d     = 1'b0;
        cnt_d         = cnt_q;
        last_owner_d  = last_owner_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d       = pick_idx;
                    grant_d       = NUM_REQ'(1) << pick_idx;
                    owner_valid_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = ST_GRANT;
                end
            end

            // Granted but not yet used: busy wins over abandon, which wins
            // over timeout. A simultaneous drop of req and busy is an abandon.
            ST_GRANT: begin
                if (owner_busy) begin
                    state_d = ST_BUSY;
                end else if (!owner_req) begin
                    grant_d       = '0;
                    owner_valid_d = 1'b0;
                    state_d       = ST_RELEASE;
                end else if (timeout_hit) begin
                    grant_d       = '0;
                    owner_valid_d = 1'b0;
                    timeout_d     = 1'b1;
                    state_d       = ST_RELEASE;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end

            // Transaction in flight: the request line no longer matters
            ST_BUSY: begin
                if (!owner_busy) begin
                    grant_d       = '0;
                    owner_valid_d = 1'b0;
                    state_d       = ST_RELEASE;
                end
            end

            // One turnaround cycle; every release path rotates priority here
            ST_RELEASE: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end

            default: begin
                grant_d       = '0;
                owner_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers, asynchronously cleared
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            cnt_q         <= '0;
            last_owner_q  <= LAST_OWNER_RST;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            timeout_q     <= timeout_d;
            cnt_q         <= cnt_d;
            last_owner_q  <= last_owner_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from registers
    // ------------------------------------------------------------------------
    assign abtr_grant_o    = grant_q;
    assign owner_id_o      = owner_q;
    assign owner_valid_o   = owner_valid_q;
    assign timeout_pulse_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter_rr
// Description : Directed bench for bus_arbiter_rr (GRANT_TIMEOUT = 4).
//               Inputs change 1 ns after the rising edge; outputs are checked
//               at the same point, so each step sees the registered result of
//               the previous edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;

    localparam int NUM_REQ = 4;
    localparam int GT      = 4;
    localparam int OW      = 2;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] busy;
    logic [NUM_REQ-1:0] grant;
    logic [OW-1:0]      owner_id;
    logic               owner_valid;
    logic               tpulse;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .NUM_REQ       (NUM_REQ),
        .GRANT_TIMEOUT (GT),
        .OWNER_W       (OW)
    ) dut (
        .clk_i           (clk),
        .reset_ni        (reset_n),
        .abtr_reqcyc_i   (req),
        .bus_busy_i      (busy),
        .abtr_grant_o    (grant),
        .owner_id_o      (owner_id),
        .owner_valid_o   (owner_valid),
        .timeout_pulse_o (tpulse)
    );

    // One comparison: counts it and reports any miss
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Checks all outputs; owner_id is only meaningful while owner_valid is set
    task automatic chk_out(input string tag, input logic [3:0] g, input logic v,
                           input logic [1:0] id, input logic tp);
        chk({tag, "_grant"}, 32'(grant), 32'(g));
        chk({tag, "_valid"}, 32'(owner_valid), 32'(v));
        chk({tag, "_tpulse"}, 32'(tpulse), 32'(tp));
        if (v) chk({tag, "_owner"}, 32'(owner_id), 32'(id));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants, sampled on the falling edge while out of reset
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("onehot0", 32'($onehot0(grant)), 32'd1);
            chk("grant_implies_valid", 32'((grant == 4'b0000) || owner_valid), 32'd1);
        end
    end

    // Watchdog so the bench always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5];
        logic [3:0] g;
        order = '{0, 1, 2, 3, 0};

        // ---------------- reset state ----------------
        reset_n = 1'b0;
        req     = 4'b0000;
        busy    = 4'b0000;
        tick();
        tick();
        chk_out("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        chk("reset_owner_id", 32'(owner_id), 32'd0);
        reset_n = 1'b1;

        // ---------------- single requester ----------------
        // cycle 0
        req = 4'b0010;
        tick();                                        // cycle 1
        chk_out("t1_c1", 4'b0010, 1'b1, 2'd1, 1'b0);
        tick();                                        // cycle 2
        chk_out("t1_c2", 4'b0010, 1'b1, 2'd1, 1'b0);
        busy = 4'b0010;                                // high cycles 2..9
        req  = 4'b0000;                                // busy beats abandon
        for (int c = 3; c <= 10; c++) begin
            tick();
            chk_out("t1_hold", 4'b0010, 1'b1, 2'd1, 1'b0);
            if (c == 10) busy = 4'b0000;
        end
        tick();                                        // cycle 11
        chk_out("t1_c11", 4'b0000, 1'b0, 2'd0, 1'b0);
        tick();                                        // cycle 12
        chk_out("t1_c12", 4'b0000, 1'b0, 2'd0, 1'b0);

        // ---------------- contention from reset ----------------
        reset_n = 1'b0;
        req     = 4'b1111;
        busy    = 4'b0000;
        tick();
        tick();
        reset_n = 1'b1;
        tick();                                        // first grant cycle
        for (int k = 0; k < 5; k++) begin
            g = 4'(1 << order[k]);
            chk_out("t2_grant", g, 1'b1, 2'(order[k]), 1'b0);
            busy = g;
            for (int j = 0; j < 3; j++) begin
                tick();
                chk_out("t2_busy", g, 1'b1, 2'(order[k]), 1'b0);
            end
            busy = 4'b0000;
            if (k == 4) req = 4'b0000;
            tick();
            chk_out("t2_release", 4'b0000, 1'b0, 2'd0, 1'b0);
            tick();
            chk_out("t2_idle", 4'b0000, 1'b0, 2'd0, 1'b0);
            tick();
        end

        // ---------------- abandon (last owner = 0) ----------------
        req = 4'b1100;                                 // a0
        tick();                                        // a1
        chk_out("t3_a1", 4'b0100, 1'b1, 2'd2, 1'b0);
        tick();                                        // a2
        chk_out("t3_a2", 4'b0100, 1'b1, 2'd2, 1'b0);
        req = 4'b1000;
        tick();                                        // a3: dropped, no pulse
        chk_out("t3_a3", 4'b0000, 1'b0, 2'd0, 1'b0);
        tick();                                        // a4
        chk_out("t3_a4", 4'b0000, 1'b0, 2'd0, 1'b0);

        // ---------------- timeout on requester 3 ----------------
        for (int c = 5; c <= 8; c++) begin
            tick();
            chk_out("t4_hold", 4'b1000, 1'b1, 2'd3, 1'b0);
        end
        tick();                                        // a9: revoke edge
        chk_out("t4_revoke", 4'b0000, 1'b0, 2'd0, 1'b1);
        req = 4'b1001;
        tick();                                        // a10
        chk_out("t4_after", 4'b0000, 1'b0, 2'd0, 1'b0);
        tick();                                        // a11: 0 wins over 3
        chk_out("t4_next", 4'b0001, 1'b1, 2'd0, 1'b0);

        // ---------------- non-owner busy ----------------
        busy = 4'b0100;
        tick();
        chk_out("t6_a12", 4'b0001, 1'b1, 2'd0, 1'b0);
        tick();
        chk_out("t6_a13", 4'b0001, 1'b1, 2'd0, 1'b0);
        busy = 4'b0001;
        tick();
        chk_out("t6_busy", 4'b0001, 1'b1, 2'd0, 1'b0);
        busy = 4'b0000;
        req  = 4'b0000;
        tick();
        chk_out("t6_release", 4'b0000, 1'b0, 2'd0, 1'b0);
        tick();
        chk_out("t6_idle", 4'b0000, 1'b0, 2'd0, 1'b0);

        // ---------------- reset mid-BUSY ----------------
        req = 4'b0010;
        tick();
        chk_out("t5_grant", 4'b0010, 1'b1, 2'd1, 1'b0);
        busy = 4'b0010;
        req  = 4'b1111;
        tick();
        chk_out("t5_busy", 4'b0010, 1'b1, 2'd1, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk_out("t5_async", 4'b0000, 1'b0, 2'd0, 1'b0);
        tick();
        chk_out("t5_inreset", 4'b0000, 1'b0, 2'd0, 1'b0);
        reset_n = 1'b1;
        busy    = 4'b0000;
        tick();
        chk_out("t5_first", 4'b0001, 1'b1, 2'd0, 1'b0);
        req = 4'b0000;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
